half_adder_checker: RTL and testbench

Synthesizable self-checking response monitor for the half-adder cell. It sits on the response side of the cell under test: it samples each applied vector (a, b) together with the cell's observed sum and carry, and compares them against the golden result. It counts vectors, mismatches and input-combination coverage, and reports pass/fail when a programmed number of vectors has been checked. It is the on-chip counterpart to the stimulus sequence that drives the cell.

---
 rtl/half_adder_checker_if.sv | 13 +
 rtl/half_adder_checker.sv | 152 +++++++++++++++
 tb/tb_half_adder_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/half_adder_checker_if.sv
// Vector bus from the half-adder stimulus/response side into half_adder_checker.
// The master drives the run control and each applied vector with its observed result.
interface half_adder_checker_if;
  logic start;
  logic in_valid;
  logic in_a;
  logic in_b;
  logic in_sum;
  logic in_carry;

  modport master (output start, in_valid, in_a, in_b, in_sum, in_carry);
  modport slave  (input  start, in_valid, in_a, in_b, in_sum, in_carry);
endinterface

// File: rtl/half_adder_checker.sv
// On-chip response monitor for the half-adder cell: counts vectors, errors and coverage.
// Optional macro HA_CHECK_COVERAGE_EN builds coverage flops and makes full coverage part of pass.
module half_adder_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int ERR_W       = 8,
  localparam int VW         = $clog2(NUM_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  half_adder_checker_if.slave  vif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_count,
  output logic [VW-1:0]        vec_count,
  output logic [VW-1:0]        first_err_idx,
  output logic [3:0]           coverage
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Golden half-adder result packed as {carry, sum}.
  function automatic logic [1:0] golden(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  state_t           state_r, state_s;
  logic             busy_r, done_r, pass_r, mismatch_r;
  logic [ERR_W-1:0] err_count_r;
  logic [VW-1:0]    vec_count_r, first_err_idx_r, vec_next_s;
  logic             accept_s, fail_s, last_s, err_sat_s, cov_ok_s, pass_next_s;

  assign accept_s    = (state_r == RUN) && vif.in_valid && !vif.start;
  // Case equality so that X/Z on an observed bit is reported as a failure in simulation.
  assign fail_s      = !({vif.in_carry, vif.in_sum} === golden(vif.in_a, vif.in_b));
  assign vec_next_s  = vec_count_r + VW'(1);
  assign last_s      = accept_s && (vec_next_s == VW'(NUM_VECTORS));
  assign err_sat_s   = (err_count_r == {ERR_W{1'b1}});
  assign pass_next_s = (err_count_r == {ERR_W{1'b0}}) && !fail_s && cov_ok_s;

`ifdef HA_CHECK_COVERAGE_EN
  logic [3:0] coverage_r, cov_hit_s;

  // One-hot of the input combination carried by the beat being accepted.
  always_comb begin
    cov_hit_s = 4'b0000;
    if (accept_s) begin
      cov_hit_s[{vif.in_a, vif.in_b}] = 1'b1;
    end else begin
      cov_hit_s = 4'b0000;
    end
  end

  // Sticky coverage bits, cleared by reset or a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coverage_r <= 4'b0000;
    end else if (vif.start) begin
      coverage_r <= 4'b0000;
    end else begin
      coverage_r <= coverage_r | cov_hit_s;
    end
  end

  assign cov_ok_s = ((coverage_r | cov_hit_s) == 4'b1111);
  assign coverage = coverage_r;
`else
  assign cov_ok_s = 1'b1;
  assign coverage = 4'b0000;
`endif

  // Next-state logic; start restarts a run from any state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (vif.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (vif.start)   state_s = RUN;
        else if (last_s) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (vif.start) state_s = RUN;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Result counters, first-error capture, mismatch pulse and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count_r     <= {VW{1'b0}};
      err_count_r     <= {ERR_W{1'b0}};
      first_err_idx_r <= {VW{1'b0}};
      pass_r          <= 1'b0;
      mismatch_r      <= 1'b0;
    end else if (vif.start) begin
      vec_count_r     <= {VW{1'b0}};
      err_count_r     <= {ERR_W{1'b0}};
      first_err_idx_r <= {VW{1'b0}};
      pass_r          <= 1'b0;
      mismatch_r      <= 1'b0;
    end else begin
      mismatch_r <= accept_s && fail_s;
      if (accept_s) begin
        vec_count_r <= vec_next_s;
        if (fail_s) begin
          if (!err_sat_s) begin
            err_count_r <= err_count_r + ERR_W'(1);
          end
          if (err_count_r == {ERR_W{1'b0}}) begin
            first_err_idx_r <= vec_count_r;
          end
        end
        if (last_s) begin
          pass_r <= pass_next_s;
        end
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign mismatch      = mismatch_r;
  assign err_count     = err_count_r;
  assign vec_count     = vec_count_r;
  assign first_err_idx = first_err_idx_r;

endmodule

// File: tb/tb_half_adder_checker.sv
// Scoreboard bench for half_adder_checker: a 4-vector instance for the functional runs
// and a 300-vector instance for error-counter saturation.
module tb_half_adder_checker;

  localparam int NV  = 4;
  localparam int VW  = 3;
  localparam int NVS = 300;
  localparam int VWS = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;

  half_adder_checker_if vif ();
  half_adder_checker_if sif ();

  logic          busy, done, pass, mismatch;
  logic [7:0]    err_count;
  logic [VW-1:0] vec_count, first_err_idx;
  logic [3:0]    coverage;

  logic           s_busy, s_done, s_pass, s_mismatch;
  logic [7:0]     s_err_count;
  logic [VWS-1:0] s_vec_count, s_first_err_idx;
  logic [3:0]     s_coverage;

  half_adder_checker #(.NUM_VECTORS(NV), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .vif(vif),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .vec_count(vec_count),
    .first_err_idx(first_err_idx), .coverage(coverage)
  );

  half_adder_checker #(.NUM_VECTORS(NVS), .ERR_W(8)) dut_sat (
    .clk(clk), .rst(rst), .vif(sif),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
    .err_count(s_err_count), .vec_count(s_vec_count),
    .first_err_idx(s_first_err_idx), .coverage(s_coverage)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the checker (0=idle, 1=run, 2=done).
  int         m_state = 0;
  int         m_vec   = 0;
  int         m_err   = 0;
  int         m_first = 0;
  logic [3:0] m_cov   = 4'b0000;

  typedef struct {
    logic mm;
    int   vec;
    int   err;
    logic done;
    logic busy;
  } exp_t;

  exp_t sb[$];

  task automatic beat(input logic a, input logic b, input logic s, input logic c);
    exp_t e;
    logic bad;
    @(negedge clk);
    vif.in_a = a; vif.in_b = b; vif.in_sum = s; vif.in_carry = c;
    vif.in_valid = 1'b1;
    bad  = (s != (a ^ b)) || (c != (a & b));
    e.mm = 1'b0;
    if (m_state == 1) begin
      if (bad) begin
        if (m_err == 0) m_first = m_vec;
        if (m_err < 255) m_err++;
        e.mm = 1'b1;
      end
      m_cov[{a, b}] = 1'b1;
      m_vec++;
      if (m_vec == NV) m_state = 2;
    end
    e.vec  = m_vec;
    e.err  = m_err;
    e.done = (m_state == 2);
    e.busy = (m_state == 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    e = sb.pop_front();
    check_val("beat_mismatch", {31'd0, mismatch}, {31'd0, e.mm});
    check_val("beat_vec_count", {29'd0, vec_count}, e.vec);
    check_val("beat_err_count", {24'd0, err_count}, e.err);
    check_val("beat_done", {31'd0, done}, {31'd0, e.done});
    check_val("beat_busy", {31'd0, busy}, {31'd0, e.busy});
  endtask

  // Start pulse, optionally with a wrong beat in the same cycle that must be discarded.
  task automatic do_start(input logic with_beat);
    @(negedge clk);
    vif.start = 1'b1;
    vif.in_valid = with_beat;
    vif.in_a = 1'b1; vif.in_b = 1'b1; vif.in_sum = 1'b1; vif.in_carry = 1'b1;
    m_state = 1; m_vec = 0; m_err = 0; m_first = 0; m_cov = 4'b0000;
    @(posedge clk);
    #1;
    vif.start = 1'b0;
    vif.in_valid = 1'b0;
    check_val("start_busy", {31'd0, busy}, 32'd1);
    check_val("start_done", {31'd0, done}, 32'd0);
    check_val("start_vec", {29'd0, vec_count}, 32'd0);
    check_val("start_err", {24'd0, err_count}, 32'd0);
    check_val("start_mismatch", {31'd0, mismatch}, 32'd0);
  endtask

  task automatic check_final();
    logic exp_pass;
    logic [3:0] exp_cov;
`ifdef HA_CHECK_COVERAGE_EN
    exp_pass = (m_err == 0) && (m_cov == 4'b1111);
    exp_cov  = m_cov;
`else
    exp_pass = (m_err == 0);
    exp_cov  = 4'b0000;
`endif
    check_val("final_pass", {31'd0, pass}, {31'd0, exp_pass});
    check_val("final_first_err", {29'd0, first_err_idx}, m_first);
    check_val("final_coverage", {28'd0, coverage}, {28'd0, exp_cov});
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check_val({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    check_val({tag, "_err"}, {24'd0, err_count}, 32'd0);
    check_val({tag, "_vec"}, {29'd0, vec_count}, 32'd0);
    check_val({tag, "_first"}, {29'd0, first_err_idx}, 32'd0);
    check_val({tag, "_cov"}, {28'd0, coverage}, 32'd0);
  endtask

  initial begin
    vif.start = 1'b0; vif.in_valid = 1'b0;
    vif.in_a = 1'b0; vif.in_b = 1'b0; vif.in_sum = 1'b0; vif.in_carry = 1'b0;
    sif.start = 1'b0; sif.in_valid = 1'b0;
    sif.in_a = 1'b0; sif.in_b = 1'b0; sif.in_sum = 1'b0; sif.in_carry = 1'b0;

    #1 rst = 1'b1;
    #2 check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Beats in IDLE are ignored
    beat(1'b1, 1'b0, 1'b0, 1'b1);

    // Correct run with a discarded beat in the start cycle
    do_start(1'b1);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    check_final();
    beat(1'b0, 1'b0, 1'b1, 1'b1);  // ignored in DONE
    check_final();

    // Injected error on the third beat
    do_start(1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    check_final();

    // Coverage hole: all beats 00, with an in_valid gap
    do_start(1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    check_final();

    // Restart mid-run
    do_start(1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b0);
    do_start(1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    check_final();

    // Asynchronous reset mid-run
    do_start(1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    m_state = 0; m_vec = 0; m_err = 0; m_first = 0; m_cov = 4'b0000;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("idle_after_rst");
    beat(1'b0, 1'b1, 1'b1, 1'b0);

    // Saturation: 300 wrong beats
    @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    for (int i = 0; i < NVS; i++) begin
      @(negedge clk);
      sif.in_a = i[0]; sif.in_b = i[1];
      sif.in_sum = ~(i[0] ^ i[1]); sif.in_carry = i[0] & i[1];
      sif.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0)   check_val("sat_first_mm", {31'd0, s_mismatch}, 32'd1);
      if (i == 150) check_val("sat_mm_held", {31'd0, s_mismatch}, 32'd1);
      if (i == 253) check_val("sat_err_254", {24'd0, s_err_count}, 32'd254);
      if (i == 254) check_val("sat_err_255", {24'd0, s_err_count}, 32'd255);
      if (i == 298) check_val("sat_not_done", {31'd0, s_done}, 32'd0);
    end
    sif.in_valid = 1'b0;
    check_val("sat_err_final", {24'd0, s_err_count}, 32'd255);
    check_val("sat_done", {31'd0, s_done}, 32'd1);
    check_val("sat_busy", {31'd0, s_busy}, 32'd0);
    check_val("sat_vec", {23'd0, s_vec_count}, 32'd300);
    check_val("sat_pass", {31'd0, s_pass}, 32'd0);
    check_val("sat_first", {23'd0, s_first_err_idx}, 32'd0);
    check_val("sat_last_mm", {31'd0, s_mismatch}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
